// File: rtl/scramble_sequencer_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | scramble_sequencer_pkg : move codes and sequencer state encoding          |
// | Rev 1.0                                                                   |
// +-------------------------------------------------------------------------+
package scramble_sequencer_pkg;

  localparam logic [1:0] MOVE_UP    = 2'b00;
  localparam logic [1:0] MOVE_DOWN  = 2'b01;
  localparam logic [1:0] MOVE_LEFT  = 2'b10;
  localparam logic [1:0] MOVE_RIGHT = 2'b11;

  // Flipping bit 0 gives the opposite move; flipping bit 1 gives a perpendicular one.
  localparam logic [1:0] C_REVERSE_MASK = 2'b01;
  localparam logic [1:0] C_PERP_MASK    = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/scramble_sequencer_move_filter.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | move_filter : replaces an exact reversal of the previous move with a      |
// | perpendicular move. Rev 1.0                                               |
// +-------------------------------------------------------------------------+
module move_filter
  import scramble_sequencer_pkg::*;
(
  input  logic [1:0] raw,
  input  logic [1:0] prev,
  input  logic       prev_valid,
  output logic [1:0] move_dir
);

  logic w_reversal;

  assign w_reversal = prev_valid && (raw == (prev ^ C_REVERSE_MASK));
  assign move_dir   = w_reversal ? (raw ^ C_PERP_MASK) : raw;

endmodule
`default_nettype wire

// File: rtl/scramble_sequencer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | scramble_sequencer : splits a random word into moves and issues them      |
// | over valid/ready with a programmable gap. Rev 1.0                         |
// +-------------------------------------------------------------------------+
module scramble_sequencer
  import scramble_sequencer_pkg::*;
#(
  parameter int NUM_MOVES  = 16,
  parameter int GAP_CYCLES = 4,
  parameter int CNT_W      = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      rand_bits,
  input  logic             move_ready,
  output logic             move_valid,
  output logic [1:0]       move_dir,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] moves_issued
);

  localparam int               C_GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [C_GAP_W-1:0] C_GAP_LOAD = C_GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] C_LAST_MOVE = CNT_W'(NUM_MOVES - 1);

  state_t             r_state;
  logic [31:0]        r_shift;
  logic [C_GAP_W-1:0] r_gap_cnt;
  logic [1:0]         r_prev;
  logic               r_prev_valid;
  logic               r_move_valid;
  logic [1:0]         r_move_dir;
  logic               r_busy;
  logic               r_done;
  logic [CNT_W-1:0]   r_moves_issued;

  logic [1:0]         w_raw;
  logic [1:0]         w_prev;
  logic               w_prev_valid;
  logic [1:0]         w_next_dir;

  // move_dir is registered, so the filter sees the move about to be presented.
  always_comb begin
    w_raw        = r_shift[1:0];
    w_prev       = r_prev;
    w_prev_valid = r_prev_valid;
    case (r_state)
      ST_IDLE: begin
        w_raw        = rand_bits[1:0];
        w_prev_valid = 1'b0;
      end
      ST_ISSUE: begin
        w_raw        = r_shift[3:2];
        w_prev       = r_move_dir;
        w_prev_valid = 1'b1;
      end
      default: ;
    endcase
  end

  move_filter u_move_filter (
    .raw        (w_raw),
    .prev       (w_prev),
    .prev_valid (w_prev_valid),
    .move_dir   (w_next_dir)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_shift        <= '0;
      r_gap_cnt      <= '0;
      r_prev         <= MOVE_UP;
      r_prev_valid   <= 1'b0;
      r_move_valid   <= 1'b0;
      r_move_dir     <= MOVE_UP;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_moves_issued <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_shift        <= rand_bits;
            r_moves_issued <= '0;
            r_prev_valid   <= 1'b0;
            r_move_valid   <= 1'b1;
            r_move_dir     <= w_next_dir;
            r_busy         <= 1'b1;
            r_state        <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (abort) begin
            r_move_valid <= 1'b0;
            r_move_dir   <= MOVE_UP;
            r_busy       <= 1'b0;
            r_state      <= ST_IDLE;
          end else if (move_ready) begin
            r_shift        <= r_shift >> 2;
            r_prev         <= r_move_dir;
            r_prev_valid   <= 1'b1;
            r_moves_issued <= r_moves_issued + CNT_W'(1);
            if (r_moves_issued == C_LAST_MOVE) begin
              r_move_valid <= 1'b0;
              r_move_dir   <= MOVE_UP;
              r_done       <= 1'b1;
              r_state      <= ST_DONE;
            end else if (GAP_CYCLES == 0) begin
              r_move_dir <= w_next_dir;
            end else begin
              r_gap_cnt    <= C_GAP_LOAD;
              r_move_valid <= 1'b0;
              r_move_dir   <= MOVE_UP;
              r_state      <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (r_gap_cnt == '0) begin
            r_move_valid <= 1'b1;
            r_move_dir   <= w_next_dir;
            r_state      <= ST_ISSUE;
          end else begin
            r_gap_cnt <= r_gap_cnt - C_GAP_W'(1);
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign move_valid   = r_move_valid;
  assign move_dir     = r_move_dir;
  assign busy         = r_busy;
  assign done         = r_done;
  assign moves_issued = r_moves_issued;

endmodule
`default_nettype wire

// File: doc/scramble_sequencer.md
Name: scramble_sequencer

Overview:
- Downstream consumer of the 32-bit random scramble word (RandBits) produced by the random-pattern stage.
- On a start request it latches the word and splits it into NUM_MOVES 2-bit move codes.
- Suppresses immediate move reversals, then issues the moves one at a time to the board-update logic over a valid/ready handshake, with a programmable gap between moves.
- Signals completion so the top-level FSM can leave the mix state.

Parameters:
- NUM_MOVES, 16: moves issued per scramble. Legal range 1..16, so NUM_MOVES*2 <= 32.
- GAP_CYCLES, 4: idle clocks between an accepted move and the next move_valid. 0 is legal and means back-to-back issue.
- CNT_W, 5: width of the move counter. Must satisfy 2**CNT_W > NUM_MOVES.

Ports:
- clk, input, 1: single system clock, all logic on the rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- start, input, 1: request a scramble. Sampled only in IDLE.
- abort, input, 1: cancel an in-progress scramble.
- rand_bits, input, 32: scramble word from the random stage. Sampled only on an accepted start.
- move_ready, input, 1: board logic accepts the current move.
- move_valid, output, 1: a move is presented.
- move_dir, output, 2: move code. 00 up, 01 down, 10 left, 11 right.
- busy, output, 1: high in every state except IDLE.
- done, output, 1: one-cycle pulse when all moves have been accepted.
- moves_issued, output, CNT_W: count of accepted moves in the current or last scramble.

Behaviour:
- Reset (rst_n=0 at a clk edge), from any state including mid-scramble:
  - state=IDLE; move_valid=0, move_dir=00, busy=0, done=0, moves_issued=0.
  - shift register=0, gap counter=0, prev-move register=00, prev_valid=0.
- States: IDLE, ISSUE, GAP, DONE.
- IDLE:
  - On start=1: load shift register with rand_bits, clear moves_issued and prev_valid, go to ISSUE.
  - move_valid rises the cycle after start (1-cycle latency).
- ISSUE:
  - move_valid=1.
  - raw = shift[1:0].
  - If prev_valid and raw == prev^2'b01 (exact reversal), move_dir = raw^2'b10 (perpendicular substitute). Otherwise move_dir = raw.
  - move_dir is a registered/stable value: it must not change while move_valid=1 and move_ready=0.
- Handshake accepted (move_valid & move_ready in ISSUE):
  - shift >>= 2; prev = issued move_dir; prev_valid=1; moves_issued++.
  - If moves_issued (pre-increment) == NUM_MOVES-1, go to DONE.
  - Else if GAP_CYCLES==0, stay in ISSUE: the next move is presented the very next cycle.
  - Else load gap counter with GAP_CYCLES-1 and go to GAP.
- GAP:
  - move_valid=0. Decrement the counter each cycle.
  - At 0, go to ISSUE. Exactly GAP_CYCLES cycles with move_valid=0 between moves.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - moves_issued holds NUM_MOVES until the next start or reset.
- abort=1 in ISSUE or GAP:
  - Next state IDLE, move_valid=0, no done pulse.
  - moves_issued retains its partial count.
  - Abort has priority over a same-cycle handshake: that move is not counted.
- abort in IDLE or DONE is ignored. DONE still pulses done.
- start while busy is ignored. rand_bits changes while busy have no effect.
- Reversal check applies only within one scramble. The first move is never substituted.
- Substitution is applied once and the result is not re-checked.

Decomposition:
- Shared package (e.g. game_pkg) holds:
  - Move-code constants MOVE_UP=2'b00, MOVE_DOWN=2'b01, MOVE_LEFT=2'b10, MOVE_RIGHT=2'b11.
  - The state encoding constants (IDLE, ISSUE, GAP, DONE), reused by the board-update logic.
- One natural sub-module: move_filter, the combinational reversal-substitution of raw/prev/prev_valid into move_dir. It is isolated so it can be unit-tested exhaustively (32 input combinations).
- The rest stays flat in scramble_sequencer.

Test Plan:
- Reset then start with rand_bits=32'h0000_0000, move_ready=1, GAP_CYCLES=0:
  - Raw moves are all up, none are reversals, so move_dir=00 on 16 consecutive cycles.
  - done pulses once on the cycle after the 16th acceptance; moves_issued=16.
- Start with rand_bits=32'h0000_0004 (raw move0=00 up, move1=01 down), ready=1:
  - move0=00; move1 substituted to 11 (right).
  - move2 raw=00 with prev=11: not a reversal, so it issues 00.
- GAP_CYCLES=4, ready=1: exactly 4 cycles of move_valid=0 between each accepted move.
  - Total cycles from start to done = 1 + 16 + 15*4 + 1.
- Backpressure, rand_bits=32'hD39A_41D5: hold move_ready=0 for 7 cycles on move 3.
  - move_valid stays 1 and move_dir stays stable for those 7 cycles.
  - Sequence resumes on ready with no move skipped or duplicated.
- Abort after 5 acceptances, asserted in the same cycle as a handshake:
  - IDLE next cycle, moves_issued=5, no done pulse.
  - A following start reloads rand_bits and reissues from move 0.
- rst_n=0 mid-GAP, and start pulsed while busy:
  - Reset returns all outputs to reset values on the next edge.
  - A start asserted while busy does not restart or reload.
